// File: rtl/count_monitor.sv
// count_monitor: sequence checker for a free-running counter bus.
// Each clock it registers the observed count and checks that it advanced by
// exactly one (modulo 2^WIDTH). A zero is accepted as a counter restart.
// It reports lock status, one-cycle event pulses and saturating statistics.
module count_monitor #(
    parameter int WIDTH  = 32,
    parameter int LOCK_N = 2,
    parameter int ERRW   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] cnt,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic             rst_evt,
    output logic             wrap,
    output logic [ERRW-1:0]  err_cnt,
    output logic [ERRW-1:0]  rst_cnt
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    localparam logic [3:0]      LOCK_RUN = 4'(LOCK_N);
    localparam logic [ERRW-1:0] STAT_MAX = '1;

    state_t          state;
    state_t          state_nx;
    logic [WIDTH-1:0] cnt_q;
    logic            primed;
    logic [3:0]      run;
    logic [3:0]      run_nx;

    logic            is_inc;
    logic            is_wrap;
    logic            is_zero;
    logic            is_bad;

    logic            err_nx;
    logic            rst_evt_nx;
    logic            wrap_nx;
    logic [ERRW-1:0] err_cnt_nx;
    logic [ERRW-1:0] rst_cnt_nx;

    // Lock status is the state register itself, so it is registered.
    assign locked = (state == LOCKED);

    // Classify the current sample against the previous one (INC, ZERO, BAD).
    always_comb begin
        is_inc  = 1'b0;
        is_wrap = 1'b0;
        is_zero = 1'b0;
        is_bad  = 1'b0;
        if (primed) begin
            is_inc  = (cnt == cnt_q + WIDTH'(1));
            is_wrap = is_inc && (cnt == '0);
            is_zero = !is_inc && (cnt == '0);
            is_bad  = !is_inc && !is_zero;
        end
    end

    // Next-state, run counter and event pulse decode.
    always_comb begin
        state_nx   = state;
        run_nx     = run;
        err_nx     = 1'b0;
        rst_evt_nx = 1'b0;
        wrap_nx    = is_wrap;
        unique case (state)
            UNLOCKED: begin
                if (is_inc) begin
                    if (run + 4'd1 == LOCK_RUN) begin
                        state_nx = LOCKED;
                        run_nx   = '0;
                    end else begin
                        run_nx = run + 4'd1;
                    end
                end else if (is_zero || is_bad) begin
                    run_nx = '0;
                end
            end
            LOCKED: begin
                if (is_zero) begin
                    // A zero following a zero is a counter held in reset.
                    rst_evt_nx = (cnt_q != '0);
                end else if (is_bad) begin
                    err_nx   = 1'b1;
                    state_nx = UNLOCKED;
                    run_nx   = '0;
                end
            end
            default: begin
                state_nx = UNLOCKED;
                run_nx   = '0;
            end
        endcase
    end

    // Saturating statistics; clear has priority over a coincident event.
    always_comb begin
        err_cnt_nx = err_cnt;
        rst_cnt_nx = rst_cnt;
        if (clr) begin
            err_cnt_nx = '0;
            rst_cnt_nx = '0;
        end else begin
            if (err_nx && (err_cnt != STAT_MAX)) begin
                err_cnt_nx = err_cnt + ERRW'(1);
            end
            if (rst_evt_nx && (rst_cnt != STAT_MAX)) begin
                rst_cnt_nx = rst_cnt + ERRW'(1);
            end
        end
    end

    // State, sample and registered output update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= UNLOCKED;
            cnt_q   <= '0;
            primed  <= 1'b0;
            run     <= '0;
            err     <= 1'b0;
            rst_evt <= 1'b0;
            wrap    <= 1'b0;
            err_cnt <= '0;
            rst_cnt <= '0;
        end else begin
            state   <= state_nx;
            cnt_q   <= cnt;
            primed  <= 1'b1;
            run     <= run_nx;
            err     <= err_nx;
            rst_evt <= rst_evt_nx;
            wrap    <= wrap_nx;
            err_cnt <= err_cnt_nx;
            rst_cnt <= rst_cnt_nx;
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor (LOCK_N=2, ERRW=2 so saturation is reachable).
module tb_count_monitor;

    logic        clk;
    logic        rstn;
    logic [31:0] cnt;
    logic        clr;
    logic        locked;
    logic        err;
    logic        rst_evt;
    logic        wrap;
    logic [1:0]  err_cnt;
    logic [1:0]  rst_cnt;

    int checks = 0;
    int passes = 0;

    count_monitor #(
        .WIDTH (32),
        .LOCK_N(2),
        .ERRW  (2)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .cnt    (cnt),
        .clr    (clr),
        .locked (locked),
        .err    (err),
        .rst_evt(rst_evt),
        .wrap   (wrap),
        .err_cnt(err_cnt),
        .rst_cnt(rst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample, let the edge register it, then settle 1 time unit.
    task automatic drive(input logic [31:0] v);
        cnt = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cnt  = '0;
        clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (locked !== 1'b0) $display("FAIL reset_locked got=%b exp=0", locked); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else passes++;
        checks++; if (rst_evt !== 1'b0) $display("FAIL reset_rst_evt got=%b exp=0", rst_evt); else passes++;
        checks++; if (wrap !== 1'b0) $display("FAIL reset_wrap got=%b exp=0", wrap); else passes++;
        checks++; if (err_cnt !== 2'd0) $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); else passes++;
        checks++; if (rst_cnt !== 2'd0) $display("FAIL reset_rst_cnt got=%0d exp=0", rst_cnt); else passes++;
        rstn = 1'b1;
    endtask

    // Counter released at 0 and free-running to 20.
    task automatic test_lock_track();
        int ev = 0;
        for (int v = 0; v <= 20; v++) begin
            drive(32'(v));
            if (err || rst_evt || wrap) ev++;
            if (v == 1) begin
                checks++; if (locked !== 1'b0) $display("FAIL lock_early got=%b exp=0", locked); else passes++;
            end
            if (v == 2) begin
                checks++; if (locked !== 1'b1) $display("FAIL lock_at_2 got=%b exp=1", locked); else passes++;
            end
        end
        checks++; if (ev !== 0) $display("FAIL track_events got=%0d exp=0", ev); else passes++;
        checks++; if (err_cnt !== 2'd0) $display("FAIL track_err_cnt got=%0d exp=0", err_cnt); else passes++;
        checks++; if (rst_cnt !== 2'd0) $display("FAIL track_rst_cnt got=%0d exp=0", rst_cnt); else passes++;
    endtask

    // Counter restarted while locked, held at 0 for 5 cycles, then released.
    task automatic test_restart();
        int rst_pulses = 0;
        int err_pulses = 0;
        int unlocked_n = 0;
        for (int i = 0; i < 5; i++) begin
            drive('0);
            if (rst_evt) rst_pulses++;
            if (err) err_pulses++;
            if (!locked) unlocked_n++;
            if (i == 0) begin
                checks++; if (rst_evt !== 1'b1) $display("FAIL restart_pulse got=%b exp=1", rst_evt); else passes++;
            end
        end
        for (int v = 1; v <= 100; v++) begin
            drive(32'(v));
            if (rst_evt) rst_pulses++;
            if (err) err_pulses++;
            if (!locked) unlocked_n++;
        end
        checks++; if (rst_pulses !== 1) $display("FAIL restart_pulse_count got=%0d exp=1", rst_pulses); else passes++;
        checks++; if (rst_cnt !== 2'd1) $display("FAIL restart_rst_cnt got=%0d exp=1", rst_cnt); else passes++;
        checks++; if (err_pulses !== 0) $display("FAIL restart_err got=%0d exp=0", err_pulses); else passes++;
        checks++; if (unlocked_n !== 0) $display("FAIL restart_unlocked got=%0d exp=0", unlocked_n); else passes++;
    endtask

    // Locked at 100, glitch to 105, then resume 106, 107, 108.
    task automatic test_glitch();
        drive(32'd105);
        checks++; if (err !== 1'b1) $display("FAIL glitch_err got=%b exp=1", err); else passes++;
        checks++; if (locked !== 1'b0) $display("FAIL glitch_locked got=%b exp=0", locked); else passes++;
        checks++; if (err_cnt !== 2'd1) $display("FAIL glitch_err_cnt got=%0d exp=1", err_cnt); else passes++;
        drive(32'd106);
        checks++; if (err !== 1'b0) $display("FAIL glitch_err_once got=%b exp=0", err); else passes++;
        checks++; if (locked !== 1'b0) $display("FAIL glitch_relock_early got=%b exp=0", locked); else passes++;
        drive(32'd107);
        checks++; if (locked !== 1'b1) $display("FAIL glitch_relock got=%b exp=1", locked); else passes++;
        drive(32'd108);
        checks++; if (err_cnt !== 2'd1) $display("FAIL glitch_err_cnt_final got=%0d exp=1", err_cnt); else passes++;
    endtask

    // Jump near the top (expected err), relock, then wrap max -> 0.
    task automatic test_wrap();
        int wraps = 0;
        int others = 0;
        drive(32'hFFFF_FFFC);
        checks++; if (err !== 1'b1) $display("FAIL wrap_entry_err got=%b exp=1", err); else passes++;
        drive(32'hFFFF_FFFD);
        if (wrap) wraps++;
        drive(32'hFFFF_FFFE);
        if (wrap) wraps++;
        checks++; if (locked !== 1'b1) $display("FAIL wrap_locked got=%b exp=1", locked); else passes++;
        drive(32'hFFFF_FFFF);
        if (wrap) wraps++;
        if (err || rst_evt) others++;
        drive(32'h0000_0000);
        checks++; if (wrap !== 1'b1) $display("FAIL wrap_pulse got=%b exp=1", wrap); else passes++;
        if (wrap) wraps++;
        if (err || rst_evt) others++;
        drive(32'h0000_0001);
        if (wrap) wraps++;
        if (err || rst_evt) others++;
        checks++; if (wraps !== 1) $display("FAIL wrap_count got=%0d exp=1", wraps); else passes++;
        checks++; if (others !== 0) $display("FAIL wrap_other_events got=%0d exp=0", others); else passes++;
        checks++; if (rst_cnt !== 2'd1) $display("FAIL wrap_rst_cnt got=%0d exp=1", rst_cnt); else passes++;
        checks++; if (err_cnt !== 2'd2) $display("FAIL wrap_err_cnt got=%0d exp=2", err_cnt); else passes++;
    endtask

    // Clear, then 5 isolated BAD samples saturate err_cnt at 3, then clr beats a 6th.
    task automatic test_saturation_clr();
        clr = 1'b1;
        drive(32'd2);
        clr = 1'b0;
        checks++; if (err_cnt !== 2'd0) $display("FAIL clr_err_cnt got=%0d exp=0", err_cnt); else passes++;
        checks++; if (rst_cnt !== 2'd0) $display("FAIL clr_rst_cnt got=%0d exp=0", rst_cnt); else passes++;
        for (int i = 0; i < 5; i++) begin
            int base;
            int exp_cnt;
            base    = 1000 * (i + 1);
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
            drive(32'(base));
            checks++; if (err !== 1'b1) $display("FAIL sat_err_%0d got=%b exp=1", i, err); else passes++;
            checks++; if (err_cnt !== 2'(exp_cnt)) $display("FAIL sat_err_cnt_%0d got=%0d exp=%0d", i, err_cnt, exp_cnt); else passes++;
            drive(32'(base + 1));
            drive(32'(base + 2));
            checks++; if (locked !== 1'b1) $display("FAIL sat_relock_%0d got=%b exp=1", i, locked); else passes++;
        end
        clr = 1'b1;
        drive(32'd9000);
        clr = 1'b0;
        checks++; if (err !== 1'b1) $display("FAIL clr_event_err got=%b exp=1", err); else passes++;
        checks++; if (err_cnt !== 2'd0) $display("FAIL clr_event_err_cnt got=%0d exp=0", err_cnt); else passes++;
    endtask

    // Build err_cnt=2 while locked, then drop rstn mid-cycle.
    task automatic test_async_reset();
        int err_pulses = 0;
        drive(32'd9001);
        drive(32'd9002);
        drive(32'd7000);
        drive(32'd7001);
        drive(32'd7002);
        drive(32'd6000);
        drive(32'd6001);
        drive(32'd6002);
        checks++; if (err_cnt !== 2'd2) $display("FAIL pre_reset_err_cnt got=%0d exp=2", err_cnt); else passes++;
        checks++; if (locked !== 1'b1) $display("FAIL pre_reset_locked got=%b exp=1", locked); else passes++;
        #3;
        rstn = 1'b0;
        #1;
        checks++; if (locked !== 1'b0) $display("FAIL async_locked got=%b exp=0", locked); else passes++;
        checks++; if (err_cnt !== 2'd0) $display("FAIL async_err_cnt got=%0d exp=0", err_cnt); else passes++;
        checks++; if ({err, rst_evt, wrap, rst_cnt} !== 5'd0) $display("FAIL async_others got=%b exp=00000", {err, rst_evt, wrap, rst_cnt}); else passes++;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive(32'd1);
        if (err) err_pulses++;
        drive(32'd2);
        if (err) err_pulses++;
        checks++; if (locked !== 1'b0) $display("FAIL post_reset_prime_only got=%b exp=0", locked); else passes++;
        drive(32'd3);
        if (err) err_pulses++;
        checks++; if (locked !== 1'b1) $display("FAIL post_reset_relock got=%b exp=1", locked); else passes++;
        checks++; if (err_pulses !== 0) $display("FAIL post_reset_err got=%0d exp=0", err_pulses); else passes++;
    endtask

    initial begin
        test_reset();
        test_lock_track();
        test_restart();
        test_glitch();
        test_wrap();
        test_saturation_clr();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
